// File: rtl/intack_seq.sv
// rtl/intack_seq.sv - V30 interrupt acknowledge sequencer: two-pulse INTA handshake, vector capture, CPU valid/ack.
// Define INTACK_NMI_EN to compile in NMI edge detection and arbitration ahead of the maskable request.
module intack_seq #(
  parameter int unsigned INTA_WIDTH = 2,
  parameter int unsigned INTA_GAP   = 1,
  parameter logic [7:0]  NMI_VECTOR = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_in,
  input  logic [7:0] vector_in,
  output logic       int_done,
  input  logic       nmi_in,
  input  logic       cpu_if,
  input  logic       cpu_boundary,
  output logic       inta_n,
  output logic       int_valid,
  output logic [7:0] int_vec,
  input  logic       int_ack,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_INTA1, S_GAP, S_INTA2, S_DONE, S_PRESENT
  } state_e;

  localparam logic [3:0] WIDTH_LD = 4'(INTA_WIDTH - 1);
  localparam logic [3:0] GAP_LD   = 4'(INTA_GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] vec_q, vec_d;
  logic       inta_n_q, inta_n_d;
  logic       int_done_q, int_done_d;
  logic       int_valid_q, int_valid_d;
  logic       busy_q, busy_d;
  logic       nmi_take;

`ifdef INTACK_NMI_EN
  logic nmi_hist_q;
  logic nmi_pending_q;

  // A fresh edge on the same cycle the pending flag is served re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_hist_q    <= 1'b0;
      nmi_pending_q <= 1'b0;
    end else begin
      nmi_hist_q    <= nmi_in;
      nmi_pending_q <= (nmi_pending_q & ~nmi_take) | (nmi_in & ~nmi_hist_q);
    end
  end
`else
  logic nmi_pending_q;
  logic nmi_unused;
  assign nmi_pending_q = 1'b0;
  assign nmi_unused    = nmi_in ^ (|NMI_VECTOR);
`endif

  assign nmi_take = (state_q == S_IDLE) && cpu_boundary && nmi_pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      vec_q       <= 8'h00;
      inta_n_q    <= 1'b1;
      int_done_q  <= 1'b0;
      int_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      inta_n_q    <= inta_n_d;
      int_done_q  <= int_done_d;
      int_valid_q <= int_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (nmi_take) begin
          vec_d   = NMI_VECTOR;
          state_d = S_PRESENT;
        end else if (cpu_boundary && cpu_if && irq_in) begin
          cnt_d   = WIDTH_LD;
          state_d = S_INTA1;
        end
      end
      S_INTA1: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = WIDTH_LD;
          state_d = S_INTA2;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_INTA2: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // The controller's vector register is stable while its done strobe is in flight.
      S_DONE: begin
        vec_d   = vector_in;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (int_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so every output comes straight from a flop.
  always_comb begin
    inta_n_d    = !((state_d == S_INTA1) || (state_d == S_INTA2));
    int_done_d  = (state_d == S_DONE);
    int_valid_d = (state_d == S_PRESENT);
    busy_d      = (state_d != S_IDLE);
  end

  assign inta_n    = inta_n_q;
  assign int_done  = int_done_q;
  assign int_valid = int_valid_q;
  assign int_vec   = vec_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_intack_seq.sv
// tb/tb_intack_seq.sv - Scoreboard bench for intack_seq: IRQ timing, masking, NMI arbitration, reset abort.
module tb_intack_seq;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, sel;
  logic       irq_in, nmi_in, cpu_if, cpu_boundary, int_ack;
  logic [7:0] vector_in;

  logic       inta_n_a, int_done_a, int_valid_a, busy_a;
  logic       inta_n_b, int_done_b, int_valid_b, busy_b;
  logic [7:0] int_vec_a, int_vec_b;

  wire        inta_n_m    = sel ? inta_n_b    : inta_n_a;
  wire        int_done_m  = sel ? int_done_b  : int_done_a;
  wire        int_valid_m = sel ? int_valid_b : int_valid_a;
  wire        busy_m      = sel ? busy_b      : busy_a;
  wire [7:0]  int_vec_m   = sel ? int_vec_b   : int_vec_a;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         W, G;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (int_done_m) done_cnt++;

  intack_seq u_dut_a (
    .clk(clk), .rst(rst_a), .irq_in(irq_in), .vector_in(vector_in), .int_done(int_done_a),
    .nmi_in(nmi_in), .cpu_if(cpu_if), .cpu_boundary(cpu_boundary), .inta_n(inta_n_a),
    .int_valid(int_valid_a), .int_vec(int_vec_a), .int_ack(int_ack), .busy(busy_a)
  );

  intack_seq #(.INTA_WIDTH(3), .INTA_GAP(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .irq_in(irq_in), .vector_in(vector_in), .int_done(int_done_b),
    .nmi_in(nmi_in), .cpu_if(cpu_if), .cpu_boundary(cpu_boundary), .inta_n(inta_n_b),
    .int_valid(int_valid_b), .int_vec(int_vec_b), .int_ack(int_ack), .busy(busy_b)
  );

  // Caller is positioned at a negedge; the boundary is sampled at the next posedge.
  task automatic irq_seq(input logic [7:0] v, input bit noisy, input bit nmi_pulses);
    int n;
    logic [7:0] e;
    logic e_inta, e_done, e_valid;
    n = 2 * W + G + 2;
    irq_in = 1'b1;
    cpu_if = 1'b1;
    vector_in = noisy ? ~v : v;
    exp_q.push_back(v);
    cpu_boundary = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cpu_boundary = noisy && (k == 1);
      if (noisy) begin
        if (k == 1) irq_in = 1'b0;
        int_ack = (k == 3);
        if (k == 2 * W + G + 1) vector_in = v;
        if (k == n) vector_in = 8'hFF;
      end
      if (nmi_pulses) nmi_in = (k == W + G + 1) || (k == W + G + 3);
      e_inta  = !((k <= W) || (k > W + G && k <= 2 * W + G));
      e_done  = (k == 2 * W + G + 1);
      e_valid = (k == n);
      checks += 4;
      if (inta_n_m !== e_inta) begin
        errors++; $display("FAIL inta_n k=%0d got %b exp %b", k, inta_n_m, e_inta);
      end
      if (int_done_m !== e_done) begin
        errors++; $display("FAIL int_done k=%0d got %b exp %b", k, int_done_m, e_done);
      end
      if (int_valid_m !== e_valid) begin
        errors++; $display("FAIL int_valid k=%0d got %b exp %b", k, int_valid_m, e_valid);
      end
      if (busy_m !== 1'b1) begin
        errors++; $display("FAIL busy_seq k=%0d got %b exp 1", k, busy_m);
      end
      if (k == n) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL scoreboard_empty got %h exp queued vector", int_vec_m);
        end else begin
          e = exp_q.pop_front();
          if (int_vec_m !== e) begin
            errors++; $display("FAIL int_vec got %h exp %h", int_vec_m, e);
          end
        end
        int_ack = 1'b1;
      end
    end
    @(negedge clk);
    int_ack = 1'b0;
    checks += 2;
    if (int_valid_m !== 1'b0) begin
      errors++; $display("FAIL valid_after_ack got %b exp 0", int_valid_m);
    end
    if (busy_m !== 1'b0) begin
      errors++; $display("FAIL busy_after_ack got %b exp 0", busy_m);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    irq_in = 0; nmi_in = 0; cpu_if = 0; cpu_boundary = 0; int_ack = 0; vector_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    checks += 5;
    if (inta_n_m !== 1'b1)    begin errors++; $display("FAIL rst_inta_n got %b exp 1", inta_n_m); end
    if (int_done_m !== 1'b0)  begin errors++; $display("FAIL rst_int_done got %b exp 0", int_done_m); end
    if (int_valid_m !== 1'b0) begin errors++; $display("FAIL rst_int_valid got %b exp 0", int_valid_m); end
    if (int_vec_m !== 8'h00)  begin errors++; $display("FAIL rst_int_vec got %h exp 00", int_vec_m); end
    if (busy_m !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy_m); end
  endtask

  task automatic test_if_masked();
    irq_in = 1'b1; cpu_if = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_boundary = 1'b1;
      @(negedge clk);
      cpu_boundary = 1'b0;
      @(negedge clk);
      checks += 2;
      if (inta_n_m !== 1'b1) begin errors++; $display("FAIL masked_inta_n got %b exp 1", inta_n_m); end
      if (busy_m !== 1'b0)   begin errors++; $display("FAIL masked_busy got %b exp 0", busy_m); end
    end
    irq_seq(8'h4B, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    irq_seq(8'h11, 1'b0, 1'b0);
    irq_seq(8'h22, 1'b0, 1'b0);
  endtask

`ifdef INTACK_NMI_EN
  task automatic present_nmi();
    logic [7:0] e;
    exp_q.push_back(8'h02);
    cpu_boundary = 1'b1;
    @(negedge clk);
    cpu_boundary = 1'b0;
    e = exp_q.pop_front();
    checks += 3;
    if (int_valid_m !== 1'b1) begin errors++; $display("FAIL nmi_valid got %b exp 1", int_valid_m); end
    if (int_vec_m !== e)      begin errors++; $display("FAIL nmi_vec got %h exp %h", int_vec_m, e); end
    if (inta_n_m !== 1'b1)    begin errors++; $display("FAIL nmi_inta_n got %b exp 1", inta_n_m); end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    checks++;
    if (int_valid_m !== 1'b0) begin errors++; $display("FAIL nmi_ack got %b exp 0", int_valid_m); end
  endtask

  task automatic test_nmi_priority();
    irq_in = 1'b1; cpu_if = 1'b1; nmi_in = 1'b1;
    @(negedge clk);
    nmi_in = 1'b0;
    @(negedge clk);
    present_nmi();
    irq_seq(8'h5C, 1'b0, 1'b0);
  endtask

  task automatic test_nmi_during_seq();
    irq_seq(8'h77, 1'b0, 1'b1);
    irq_in = 1'b0; cpu_if = 1'b0;
    present_nmi();
    cpu_boundary = 1'b1;
    @(negedge clk);
    cpu_boundary = 1'b0;
    checks += 2;
    if (busy_m !== 1'b0)      begin errors++; $display("FAIL nmi_collapse_busy got %b exp 0", busy_m); end
    if (int_valid_m !== 1'b0) begin errors++; $display("FAIL nmi_collapse_valid got %b exp 0", int_valid_m); end
  endtask
`else
  task automatic test_nmi_ignored();
    irq_seq(8'h77, 1'b0, 1'b1);
    irq_in = 1'b0; cpu_if = 1'b1; nmi_in = 1'b1;
    @(negedge clk);
    nmi_in = 1'b0;
    @(negedge clk);
    cpu_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_boundary = 1'b0;
      checks += 3;
      if (busy_m !== 1'b0)      begin errors++; $display("FAIL nmi_off_busy got %b exp 0", busy_m); end
      if (int_valid_m !== 1'b0) begin errors++; $display("FAIL nmi_off_valid got %b exp 0", int_valid_m); end
      if (inta_n_m !== 1'b1)    begin errors++; $display("FAIL nmi_off_inta_n got %b exp 1", inta_n_m); end
    end
  endtask
`endif

  task automatic test_reset_abort(input int kr);
    int d0;
    sel = 1'b1; rst_a = 1'b1; rst_b = 1'b0; W = 3; G = 2;
    @(negedge clk);
    irq_in = 1'b1; cpu_if = 1'b1; vector_in = 8'hC3; cpu_boundary = 1'b1;
    for (int k = 1; k <= kr; k++) begin
      @(negedge clk);
      cpu_boundary = 1'b0;
    end
    d0 = done_cnt;
    rst_b = 1'b1;
    #1;
    checks += 3;
    if (inta_n_m !== 1'b1)    begin errors++; $display("FAIL abort_inta_n k=%0d got %b exp 1", kr, inta_n_m); end
    if (busy_m !== 1'b0)      begin errors++; $display("FAIL abort_busy k=%0d got %b exp 0", kr, busy_m); end
    if (int_valid_m !== 1'b0) begin errors++; $display("FAIL abort_valid k=%0d got %b exp 0", kr, int_valid_m); end
    repeat (2 * W + G + 3) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort_done k=%0d got %0d exp %0d", kr, done_cnt, d0); end
    rst_b = 1'b0;
    @(negedge clk);
    irq_seq(8'h3C, 1'b0, 1'b0);
  endtask

  initial begin
    W = 2; G = 1; sel = 1'b0;
    test_reset();
    irq_seq(8'h0A, 1'b0, 1'b0);
    test_if_masked();
    irq_seq(8'hA5, 1'b1, 1'b0);
    test_back_to_back();
`ifdef INTACK_NMI_EN
    test_nmi_priority();
    test_nmi_during_seq();
`else
    test_nmi_ignored();
`endif
    test_reset_abort(4);
    test_reset_abort(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
